// File: rtl/irq_commit_sequencer.sv
// rtl/irq_commit_sequencer.sv - commit-stage interrupt sequencer between ROB retirement and CSR file
//
// Purpose:
//   On an enabled pending interrupt, stalls dispatch, waits for the ROB to drain,
//   then fires one irq_taken/flush pulse with a precise EPC followed by one fetch
//   redirect to the trap handler. Retiring mret/ecall jumps win over interrupts.
//   A drain that never completes is aborted and followed by a holdoff window, and
//   a new interrupt is only accepted once an instruction has retired after the
//   previous redirect.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   irq_req           enabled pending interrupt (already masked by mstatus.MIE)
//   rob_empty         ROB holds no instructions
//   commit_valid      at least one instruction retired this cycle
//   commit_next_pc    PC of oldest unretired instruction / next dispatch PC
//   sys_jump          mret/ecall retiring this cycle
//   pc_handler        trap vector target from CSR file
//   dispatch_stall    block dispatch into ROB
//   irq_taken         1-cycle pulse to CSR file, irq_epc valid alongside
//   irq_epc           exception PC
//   flush             1-cycle pipeline/ROB flush
//   redirect_valid    1-cycle fetch redirect, redirect_pc valid alongside
//   redirect_pc       redirect target
//   busy              sequencer not idle
//   drain_timeout     1-cycle pulse when a drain is aborted

module irq_commit_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DRAIN_MAX      = 255,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  irq_req,
  input  logic                  rob_empty,
  input  logic                  commit_valid,
  input  logic [ADDR_WIDTH-1:0] commit_next_pc,
  input  logic                  sys_jump,
  input  logic [ADDR_WIDTH-1:0] pc_handler,
  output logic                  dispatch_stall,
  output logic                  irq_taken,
  output logic [ADDR_WIDTH-1:0] irq_epc,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  busy,
  output logic                  drain_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_TAKE,
    S_REDIRECT,
    S_HOLDOFF
  } state_t;

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0] epc_q, tgt_q;
  logic                  progress_ok_q;
  logic                  dispatch_stall_q, irq_taken_q, flush_q;
  logic                  redirect_valid_q, busy_q, drain_timeout_q;

  // Shared drain/holdoff counter, saturating rather than wrapping.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        // A retiring system jump redirects on its own; the irq is looked at again next cycle.
        if (irq_req && progress_ok_q && !sys_jump) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_inc;
        if (sys_jump) begin
          state_d = S_IDLE;
        end else if (!irq_req) begin
          state_d = S_IDLE;
        end else if (rob_empty && !commit_valid) begin
          state_d = S_TAKE;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = S_HOLDOFF;
          cnt_d   = '0;
        end
      end
      S_TAKE:     state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      S_HOLDOFF: begin
        cnt_d = cnt_inc;
        if (cnt_q == HOLD_LAST) begin
          state_d = S_IDLE;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      epc_q            <= '0;
      tgt_q            <= '0;
      progress_ok_q    <= 1'b1;
      dispatch_stall_q <= 1'b0;
      irq_taken_q      <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      drain_timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      // With an empty ROB and nothing retiring, commit_next_pc is the precise EPC.
      if (state_q == S_DRAIN && state_d == S_TAKE) begin
        epc_q <= commit_next_pc;
      end
      if (state_q == S_TAKE) begin
        tgt_q <= pc_handler;
      end

      // TAKE's clear is written last so it wins over a same-cycle retirement.
      if (commit_valid) begin
        progress_ok_q <= 1'b1;
      end
      if (state_q == S_TAKE) begin
        progress_ok_q <= 1'b0;
      end

      // Outputs are registered from the next state so they line up with it.
      dispatch_stall_q <= (state_d == S_DRAIN) || (state_d == S_TAKE) || (state_d == S_REDIRECT);
      busy_q           <= (state_d != S_IDLE);
      irq_taken_q      <= (state_d == S_TAKE);
      flush_q          <= (state_d == S_TAKE);
      redirect_valid_q <= (state_d == S_REDIRECT);
      drain_timeout_q  <= (state_q == S_DRAIN) && (state_d == S_HOLDOFF);
    end
  end

  assign dispatch_stall = dispatch_stall_q;
  assign irq_taken      = irq_taken_q;
  assign irq_epc        = epc_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = tgt_q;
  assign busy           = busy_q;
  assign drain_timeout  = drain_timeout_q;

endmodule

// File: tb/tb_irq_commit_sequencer.sv
// tb/tb_irq_commit_sequencer.sv - directed self-checking bench for irq_commit_sequencer
//
// Purpose:
//   Drives directed vectors one cycle at a time, advances a phase-level model of
//   the interrupt sequence, and compares every DUT output against it each cycle,
//   plus literal expectations at the cycles the scenarios call out.
//
// Ports: none (top-level bench).

module tb_irq_commit_sequencer;

  localparam int AW       = 32;
  localparam int DMAX     = 4;
  localparam int HOLD     = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          irq_req;
  logic          rob_empty;
  logic          commit_valid;
  logic [AW-1:0] commit_next_pc;
  logic          sys_jump;
  logic [AW-1:0] pc_handler;
  logic          dispatch_stall;
  logic          irq_taken;
  logic [AW-1:0] irq_epc;
  logic          flush;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          busy;
  logic          drain_timeout;

  irq_commit_sequencer #(
    .ADDR_WIDTH    (AW),
    .DRAIN_MAX     (DMAX),
    .HOLDOFF_CYCLES(HOLD),
    .CNT_W         (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_req       (irq_req),
    .rob_empty     (rob_empty),
    .commit_valid  (commit_valid),
    .commit_next_pc(commit_next_pc),
    .sys_jump      (sys_jump),
    .pc_handler    (pc_handler),
    .dispatch_stall(dispatch_stall),
    .irq_taken     (irq_taken),
    .irq_epc       (irq_epc),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy),
    .drain_timeout (drain_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: which phase of an interrupt sequence we are in, how long we have
  // been draining, and how many holdoff cycles remain.
  localparam int P_IDLE = 0, P_DRAIN = 1, P_TAKE = 2, P_REDIR = 3, P_HOLD = 4;
  int            m_phase;
  int            m_age;
  int            m_left;
  logic [AW-1:0] m_epc;
  logic [AW-1:0] m_tgt;
  bit            m_pok;
  bit            m_to;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit pok_n;
    if (rst) begin
      m_phase = P_IDLE; m_age = 0; m_left = 0;
      m_epc = '0; m_tgt = '0; m_pok = 1'b1; m_to = 1'b0;
    end else begin
      pok_n = commit_valid ? 1'b1 : m_pok;
      if (m_phase == P_TAKE) pok_n = 1'b0;
      m_to = 1'b0;
      case (m_phase)
        P_IDLE: if (irq_req && m_pok && !sys_jump) begin
          m_phase = P_DRAIN; m_age = 0;
        end
        P_DRAIN: begin
          if (sys_jump || !irq_req) m_phase = P_IDLE;
          else if (rob_empty && !commit_valid) begin
            m_phase = P_TAKE; m_epc = commit_next_pc;
          end else if (m_age == DMAX - 1) begin
            m_phase = P_HOLD; m_left = HOLD; m_to = 1'b1;
          end else m_age++;
        end
        P_TAKE: begin
          m_tgt = pc_handler; m_phase = P_REDIR;
        end
        P_REDIR: m_phase = P_IDLE;
        default: begin
          m_left--;
          if (m_left == 0) m_phase = P_IDLE;
        end
      endcase
      m_pok = pok_n;
    end
  endtask

  task automatic compare_all();
    chk("dispatch_stall", AW'(dispatch_stall),
        AW'(m_phase == P_DRAIN || m_phase == P_TAKE || m_phase == P_REDIR));
    chk("busy", AW'(busy), AW'(m_phase != P_IDLE));
    chk("irq_taken", AW'(irq_taken), AW'(m_phase == P_TAKE));
    chk("flush", AW'(flush), AW'(m_phase == P_TAKE));
    chk("redirect_valid", AW'(redirect_valid), AW'(m_phase == P_REDIR));
    chk("drain_timeout", AW'(drain_timeout), AW'(m_to));
    if (m_phase == P_TAKE) chk("irq_epc", irq_epc, m_epc);
    if (m_phase == P_REDIR) chk("redirect_pc", redirect_pc, m_tgt);
  endtask

  // Apply one cycle of inputs, clock it, advance the model, compare.
  task automatic step(input logic r, input logic irq, input logic re, input logic cv,
                      input logic [AW-1:0] npc, input logic sj, input logic [AW-1:0] h);
    rst = r; irq_req = irq; rob_empty = re; commit_valid = cv;
    commit_next_pc = npc; sys_jump = sj; pc_handler = h;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  int to_cnt;
  int stall_cnt;

  initial begin
    rst = 1'b1; irq_req = 1'b0; rob_empty = 1'b1; commit_valid = 1'b0;
    commit_next_pc = '0; sys_jump = 1'b0; pc_handler = '0;

    // Scenario 1: empty ROB, irq at cycle 10 -> TAKE at 12, redirect at 13.
    step(1, 0, 1, 0, 32'h100, 0, 32'h80);
    step(1, 0, 1, 0, 32'h100, 0, 32'h80);
    chk("reset_busy", AW'(busy), '0);
    chk("reset_stall", AW'(dispatch_stall), '0);
    chk("reset_epc", irq_epc, '0);
    for (int c = 2; c < 10; c++) step(0, 0, 1, 0, 32'h100, 0, 32'h80);
    step(0, 1, 1, 0, 32'h100, 0, 32'h80);      // cycle 10
    chk("s1_stall_c11", AW'(dispatch_stall), 1);
    step(0, 1, 1, 0, 32'h100, 0, 32'h80);      // cycle 11
    chk("s1_taken_c12", AW'(irq_taken), 1);
    chk("s1_flush_c12", AW'(flush), 1);
    chk("s1_epc_c12", irq_epc, 32'h100);
    step(0, 0, 1, 0, 32'h100, 0, 32'h80);      // cycle 12
    chk("s1_redir_c13", AW'(redirect_valid), 1);
    chk("s1_rpc_c13", redirect_pc, 32'h80);
    step(0, 0, 1, 0, 32'h80, 0, 32'h80);       // cycle 13
    chk("s1_idle_c14", AW'(busy), 0);

    // Scenario 2: three retirements during drain, TAKE 5 cycles after irq.
    step(0, 0, 1, 1, 32'h200, 0, 32'h80);      // retire to restore progress
    step(0, 1, 0, 0, 32'h200, 0, 32'h80);      // "cycle 10"
    stall_cnt = dispatch_stall;
    step(0, 1, 0, 1, 32'h204, 0, 32'h80);
    stall_cnt += dispatch_stall;
    step(0, 1, 0, 1, 32'h208, 0, 32'h80);
    stall_cnt += dispatch_stall;
    step(0, 1, 0, 1, 32'h20C, 0, 32'h80);
    stall_cnt += dispatch_stall;
    step(0, 1, 1, 0, 32'h20C, 0, 32'h90);      // "cycle 14"
    stall_cnt += dispatch_stall;
    chk("s2_stall_11_15", AW'(stall_cnt), 5);
    chk("s2_taken_c15", AW'(irq_taken), 1);
    chk("s2_epc_c15", irq_epc, 32'h20C);
    step(0, 0, 1, 0, 32'h20C, 0, 32'h90);
    chk("s2_rpc", redirect_pc, 32'h90);
    step(0, 0, 1, 0, 32'h90, 0, 32'h90);

    // Scenario 3: sys_jump beats irq in IDLE and aborts a drain.
    step(0, 0, 1, 1, 32'h300, 0, 32'h80);
    step(0, 1, 1, 0, 32'h300, 1, 32'h80);
    chk("s3_idle_sj", AW'(busy), 0);
    step(0, 1, 0, 0, 32'h300, 0, 32'h80);
    chk("s3_drain", AW'(dispatch_stall), 1);
    step(0, 1, 1, 0, 32'h300, 1, 32'h80);
    chk("s3_abort_stall", AW'(dispatch_stall), 0);
    chk("s3_abort_taken", AW'(irq_taken), 0);
    step(0, 0, 1, 0, 32'h300, 0, 32'h80);

    // Scenario 4: drain timeout with DRAIN_MAX=4, 16-cycle holdoff, then re-entry.
    step(0, 1, 0, 0, 32'h400, 0, 32'h80);      // DRAIN entry visible
    to_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 32'h400, 0, 32'h80);
      to_cnt += drain_timeout;
    end
    step(0, 1, 0, 0, 32'h400, 0, 32'h80);      // entry + 4
    chk("s4_timeout_pulse", AW'(drain_timeout), 1);
    chk("s4_hold_stall", AW'(dispatch_stall), 0);
    stall_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, 0, 32'h400, 0, 32'h80);
      to_cnt += drain_timeout;
      stall_cnt += dispatch_stall;
      stall_cnt += busy ? 0 : 1;
    end
    chk("s4_single_pulse", AW'(to_cnt), 0);
    chk("s4_hold_16", AW'(stall_cnt), 0);
    step(0, 1, 0, 0, 32'h400, 0, 32'h80);      // entry + 20
    chk("s4_idle_after_hold", AW'(busy), 0);
    step(0, 1, 0, 0, 32'h400, 0, 32'h80);
    chk("s4_redrain", AW'(dispatch_stall), 1);
    step(0, 0, 0, 0, 32'h400, 0, 32'h80);

    // Scenario 5: irq held, no retirement after redirect -> no second drain.
    step(0, 0, 1, 1, 32'h500, 0, 32'h80);
    step(0, 1, 1, 0, 32'h500, 0, 32'hA0);
    step(0, 1, 1, 0, 32'h500, 0, 32'hA0);
    step(0, 1, 1, 0, 32'h500, 0, 32'hA0);
    step(0, 1, 1, 0, 32'hA0, 0, 32'hA0);
    stall_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 0, 32'hA0, 0, 32'hA0);
      stall_cnt += busy;
    end
    chk("s5_no_second_drain", AW'(stall_cnt), 0);
    step(0, 1, 1, 1, 32'hA4, 0, 32'hA0);       // first retirement
    step(0, 1, 1, 0, 32'hA4, 0, 32'hA0);
    chk("s5_drain_after_commit", AW'(dispatch_stall), 1);
    step(0, 0, 1, 0, 32'hA4, 0, 32'hA0);

    // Scenario 6: reset during TAKE clears everything and restores progress_ok.
    step(0, 1, 1, 0, 32'h600, 0, 32'h80);
    step(0, 1, 1, 0, 32'h600, 0, 32'h80);
    chk("s6_in_take", AW'(irq_taken), 1);
    step(1, 1, 1, 0, 32'h600, 0, 32'h80);
    chk("s6_rst_taken", AW'(irq_taken), 0);
    chk("s6_rst_redir", AW'(redirect_valid), 0);
    chk("s6_rst_epc", irq_epc, 0);
    chk("s6_rst_rpc", redirect_pc, 0);
    chk("s6_rst_busy", AW'(busy), 0);
    step(0, 1, 1, 0, 32'h600, 0, 32'h80);
    chk("s6_progress_ok", AW'(dispatch_stall), 1);
    step(0, 0, 1, 0, 32'h600, 0, 32'h80);
    step(0, 0, 1, 0, 32'h600, 0, 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
